// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
package cla_pkg;

  // Segment width (one pipeline stage) and lookahead group width.
  localparam int SEG_W = 16;
  localparam int GRP_W = 4;

  // Operation encoding for op_sub.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Result flags held in the final stage next to the full sum.
  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
  } out_flags_t;

  // Number of 16-bit segments, which is also the pipeline depth.
  function automatic int seg_count(input int width);
    return width / SEG_W;
  endfunction

endpackage

// File: rtl/cla_adder_pipe_seg.sv
// 16-bit two-level carry-lookahead segment (purely combinational).
// Four 4-bit lookahead cells produce group P/G; an upper cell produces the
// group carry-ins and the segment carry-out.
module cla16_seg
  import cla_pkg::*;
(
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout,
  output logic             grp_p,
  output logic             grp_g
);

  localparam int NGRP = SEG_W / GRP_W;

  logic [SEG_W-1:0] g;
  logic [SEG_W-1:0] p;
  logic [SEG_W-1:0] x;
  logic [NGRP-1:0]  gp;
  logic [NGRP-1:0]  gg;
  logic [NGRP-1:0]  gc;

  assign g = a & b;
  assign p = a | b;
  assign x = a ^ b;

  // First level: 4-bit lookahead cells, each with its own bit carries.
  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    logic [GRP_W-1:0] bg;
    logic [GRP_W-1:0] bp;
    logic [GRP_W-1:0] bc;

    assign bg = g[gi*GRP_W +: GRP_W];
    assign bp = p[gi*GRP_W +: GRP_W];

    assign bc[0] = gc[gi];
    assign bc[1] = bg[0] | (bp[0] & gc[gi]);
    assign bc[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & gc[gi]);
    assign bc[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                 | (bp[2] & bp[1] & bp[0] & gc[gi]);

    assign gg[gi] = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
                  | (bp[3] & bp[2] & bp[1] & bg[0]);
    assign gp[gi] = &bp;

    assign s[gi*GRP_W +: GRP_W] = x[gi*GRP_W +: GRP_W] ^ bc;
  end

  // Second level: group carries computed directly from group P/G and cin.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);

  assign grp_g = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]);
  assign grp_p = &gp;
  assign cout  = grp_g | (grp_p & cin);

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor. Stage k adds segment k; the
// segment carry is registered between stages, unconsumed operand bits are
// skewed forward and completed sum bits are deskewed so the result emerges
// aligned after NSEG cycles. A single global stall freezes every stage.
// WIDTH must be a multiple of 16 in the range 16..128.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             ovf_out,
  output logic             zero_out
);

  localparam int NSEG = seg_count(WIDTH);

  logic [NSEG-1:0]  vld;
  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Stall only when the last stage holds a result nobody is taking.
  assign advance   = !(vld[NSEG-1] && !out_ready);
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  assign out_valid = vld[NSEG-1];

  // Subtraction is A + ~B + 1; c_in is ignored in that mode.
  assign b_eff   = (op_sub == OP_ADD) ? b_in : ~b_in;
  assign cin_eff = (op_sub == OP_SUB) ? 1'b1 : c_in;

  // Per-stage valid bits shift together; bubbles are kept, not collapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (advance) begin
      vld <= (vld << 1) | NSEG'(accept);
    end
  end

  for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
    localparam int SUM_W = SEG_W * (gi + 1);
    localparam int REM_W = WIDTH - SUM_W;

    logic [SEG_W-1:0] seg_a;
    logic [SEG_W-1:0] seg_b;
    logic [SEG_W-1:0] seg_s;
    logic             seg_cin;
    logic             seg_cout;
    logic             seg_p;
    logic             seg_g;
    logic [SUM_W-1:0] sum_next;
    logic [SUM_W-1:0] sum_reg;
    logic             unused_pg;

    // Stage 0 reads the live inputs; later stages read the previous stage.
    if (gi == 0) begin : g_src
      assign seg_a    = a_in[SEG_W-1:0];
      assign seg_b    = b_eff[SEG_W-1:0];
      assign seg_cin  = cin_eff;
      assign sum_next = seg_s;
    end else begin : g_src
      assign seg_a    = g_stage[gi-1].g_fwd.a_rem_reg[SEG_W-1:0];
      assign seg_b    = g_stage[gi-1].g_fwd.b_rem_reg[SEG_W-1:0];
      assign seg_cin  = g_stage[gi-1].g_fwd.carry_reg;
      assign sum_next = {seg_s, g_stage[gi-1].sum_reg};
    end

    cla16_seg u_seg (
      .a     (seg_a),
      .b     (seg_b),
      .cin   (seg_cin),
      .s     (seg_s),
      .cout  (seg_cout),
      .grp_p (seg_p),
      .grp_g (seg_g)
    );

    // Segment P/G would only matter for lookahead across segments, which the
    // registered inter-stage carry makes unnecessary.
    assign unused_pg = seg_p ^ seg_g;

    // Completed low sum bits move forward with the beat (deskew).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_reg <= '0;
      end else if (advance) begin
        sum_reg <= sum_next;
      end
    end

    if (gi < NSEG - 1) begin : g_fwd
      logic [REM_W-1:0] a_rem_reg;
      logic [REM_W-1:0] b_rem_reg;
      logic [REM_W-1:0] a_rem_next;
      logic [REM_W-1:0] b_rem_next;
      logic             carry_reg;

      if (gi == 0) begin : g_in
        assign a_rem_next = a_in[WIDTH-1:SEG_W];
        assign b_rem_next = b_eff[WIDTH-1:SEG_W];
      end else begin : g_in
        assign a_rem_next = g_stage[gi-1].g_fwd.a_rem_reg[REM_W+SEG_W-1:SEG_W];
        assign b_rem_next = g_stage[gi-1].g_fwd.b_rem_reg[REM_W+SEG_W-1:SEG_W];
      end

      // Unconsumed operand segments and the segment carry move forward (skew).
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem_reg <= '0;
          b_rem_reg <= '0;
          carry_reg <= 1'b0;
        end else if (advance) begin
          a_rem_reg <= a_rem_next;
          b_rem_reg <= b_rem_next;
          carry_reg <= seg_cout;
        end
      end
    end else begin : g_last
      out_flags_t flags_next;
      out_flags_t flags_reg;

      // Final carry, signed overflow and zero detect from the full sum.
      always_comb begin
        flags_next       = '0;
        flags_next.carry = seg_cout;
        flags_next.ovf   = (seg_a[SEG_W-1] == seg_b[SEG_W-1]) &&
                           (seg_s[SEG_W-1] != seg_a[SEG_W-1]);
        flags_next.zero  = (sum_next == '0);
      end

      // Result flags are registered alongside the final sum.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          flags_reg <= '0;
        end else if (advance) begin
          flags_reg <= flags_next;
        end
      end

      assign sum_out  = sum_reg;
      assign c_out    = flags_reg.carry;
      assign ovf_out  = flags_reg.ovf;
      assign zero_out = flags_reg.zero;
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed bench for cla_adder_pipe: WIDTH=32 main instance plus 16- and
// 64-bit instances for latency and randomized checks against a reference sum.
module tb_cla_adder_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=32 instance
  logic        in_valid_32, in_ready_32, c_in_32, op_sub_32;
  logic        out_valid_32, out_ready_32, c_out_32, ovf_out_32, zero_out_32;
  logic [31:0] a_in_32, b_in_32, sum_out_32;

  // WIDTH=16 instance
  logic        in_valid_16, in_ready_16, c_in_16, op_sub_16;
  logic        out_valid_16, out_ready_16, c_out_16, ovf_out_16, zero_out_16;
  logic [15:0] a_in_16, b_in_16, sum_out_16;

  // WIDTH=64 instance
  logic        in_valid_64, in_ready_64, c_in_64, op_sub_64;
  logic        out_valid_64, out_ready_64, c_out_64, ovf_out_64, zero_out_64;
  logic [63:0] a_in_64, b_in_64, sum_out_64;

  cla_adder_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_32), .in_ready(in_ready_32),
    .a_in(a_in_32), .b_in(b_in_32), .c_in(c_in_32), .op_sub(op_sub_32),
    .out_valid(out_valid_32), .out_ready(out_ready_32), .sum_out(sum_out_32),
    .c_out(c_out_32), .ovf_out(ovf_out_32), .zero_out(zero_out_32)
  );

  cla_adder_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_16), .in_ready(in_ready_16),
    .a_in(a_in_16), .b_in(b_in_16), .c_in(c_in_16), .op_sub(op_sub_16),
    .out_valid(out_valid_16), .out_ready(out_ready_16), .sum_out(sum_out_16),
    .c_out(c_out_16), .ovf_out(ovf_out_16), .zero_out(zero_out_16)
  );

  cla_adder_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_64), .in_ready(in_ready_64),
    .a_in(a_in_64), .b_in(b_in_64), .c_in(c_in_64), .op_sub(op_sub_64),
    .out_valid(out_valid_64), .out_ready(out_ready_64), .sum_out(sum_out_64),
    .c_out(c_out_64), .ovf_out(ovf_out_64), .zero_out(zero_out_64)
  );

  int n_assert = 0;
  int n_fail   = 0;

  localparam int NRND = 24;
  logic [130:0] sexp [8];
  logic [130:0] e16 [NRND];
  logic [130:0] e64 [NRND];

  task automatic chk(input string tag, input logic [130:0] obs, input logic [130:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed result view: {ovf, zero, carry, sum zero-extended to 128}.
  function automatic logic [130:0] res32();
    return {ovf_out_32, zero_out_32, c_out_32, 96'h0, sum_out_32};
  endfunction
  function automatic logic [130:0] res16();
    return {ovf_out_16, zero_out_16, c_out_16, 112'h0, sum_out_16};
  endfunction
  function automatic logic [130:0] res64();
    return {ovf_out_64, zero_out_64, c_out_64, 64'h0, sum_out_64};
  endfunction
  function automatic logic [130:0] e32(input logic ov, input logic z, input logic c,
                                       input logic [31:0] s);
    return {ov, z, c, 96'h0, s};
  endfunction

  // Reference: exact (w+1)-bit sum of a + b_eff + cin_eff.
  function automatic logic [130:0] ref_model(input int w, input logic [127:0] a,
                                             input logic [127:0] b, input logic cin,
                                             input logic op);
    logic [128:0] mask;
    logic [128:0] full;
    logic [127:0] be;
    logic [127:0] s;
    logic         c;
    logic         ov;
    mask = (129'd1 << w) - 129'd1;
    be   = (op ? ~b : b) & mask[127:0];
    full = {1'b0, a} + {1'b0, be} + {128'd0, (op ? 1'b1 : cin)};
    s    = full[127:0] & mask[127:0];
    c    = full[w];
    ov   = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
    return {ov, (s == 128'd0), c, s};
  endfunction

  // One isolated beat on the 32-bit instance: check 2-cycle latency and result.
  task automatic beat32(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic op, input logic [130:0] exp);
    a_in_32 = a; b_in_32 = b; c_in_32 = cin; op_sub_32 = op;
    in_valid_32 = 1'b1; out_ready_32 = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 131'(in_ready_32), 131'd1);
    step();
    in_valid_32 = 1'b0;
    chk({tag, ".lat1"}, 131'(out_valid_32), 131'd0);
    step();
    chk({tag, ".lat2"}, 131'(out_valid_32), 131'd1);
    chk({tag, ".result"}, res32(), exp);
    $display("beat %s a=%h b=%h cin=%b op=%b -> sum=%h c=%b ovf=%b zero=%b",
             tag, a, b, cin, op, sum_out_32, c_out_32, ovf_out_32, zero_out_32);
    step();
    chk({tag, ".drain"}, 131'(out_valid_32), 131'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid_32 = 0; a_in_32 = '0; b_in_32 = '0; c_in_32 = 0; op_sub_32 = 0; out_ready_32 = 1;
    in_valid_16 = 0; a_in_16 = '0; b_in_16 = '0; c_in_16 = 0; op_sub_16 = 0; out_ready_16 = 1;
    in_valid_64 = 0; a_in_64 = '0; b_in_64 = '0; c_in_64 = 0; op_sub_64 = 0; out_ready_64 = 1;

    // Reset state
    #12;
    chk("reset.out_valid", 131'(out_valid_32), 131'd0);
    chk("reset.outputs", res32(), 131'd0);
    chk("reset.in_ready", 131'(in_ready_32), 131'd1);
    chk("reset.out_valid16", 131'(out_valid_16), 131'd0);
    chk("reset.out_valid64", 131'(out_valid_64), 131'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_reset.in_ready", 131'(in_ready_32), 131'd1);

    // Directed single beats
    beat32("add_carry16", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, e32(0, 0, 0, 32'h00010000));
    beat32("ripple",      32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, e32(0, 1, 1, 32'h00000000));
    beat32("sub_borrow",  32'h00000005, 32'h00000007, 1'b0, 1'b1, e32(0, 0, 0, 32'hFFFFFFFE));
    beat32("sub_ovf",     32'h80000000, 32'h00000001, 1'b0, 1'b1, e32(1, 0, 1, 32'h7FFFFFFF));
    beat32("sub_cin_ign", 32'h0000000A, 32'h00000003, 1'b1, 1'b1, e32(0, 0, 1, 32'h00000007));
    beat32("add_ovf",     32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, e32(1, 0, 0, 32'h80000000));
    beat32("sub_zero",    32'h12345678, 32'h12345678, 1'b0, 1'b1, e32(0, 1, 1, 32'h00000000));
    beat32("add_cin_seg", 32'h0000FFFF, 32'hFFFF0000, 1'b1, 1'b0, e32(0, 1, 1, 32'h00000000));

    // Back-to-back stream of 8 beats, results on consecutive cycles
    out_ready_32 = 1'b1;
    for (int t = 0; t <= 8; t++) begin
      if (t < 8) begin
        a_in_32 = 32'h9E3779B9 * 32'(t + 1);
        b_in_32 = 32'h7F4A7C15 ^ 32'(t << 12);
        c_in_32 = t[0];
        op_sub_32 = t[1];
        in_valid_32 = 1'b1;
        sexp[t] = ref_model(32, 128'(a_in_32), 128'(b_in_32), c_in_32, op_sub_32);
      end else begin
        in_valid_32 = 1'b0;
      end
      #1;
      chk("stream.in_ready", 131'(in_ready_32), 131'd1);
      step();
      if (t == 0) begin
        chk("stream.first_empty", 131'(out_valid_32), 131'd0);
      end else begin
        chk("stream.out_valid", 131'(out_valid_32), 131'd1);
        chk("stream.result", res32(), sexp[t-1]);
        $display("stream beat %0d sum=%h c=%b", t - 1, sum_out_32, c_out_32);
      end
    end
    step();
    chk("stream.drained", 131'(out_valid_32), 131'd0);

    // Backpressure: fill pipe with out_ready=0, hold 3 cycles, then release
    out_ready_32 = 1'b0;
    a_in_32 = 32'h11111111; b_in_32 = 32'h22222222; c_in_32 = 0; op_sub_32 = 0;
    in_valid_32 = 1'b1;
    #1;
    chk("stall.fill0_ready", 131'(in_ready_32), 131'd1);
    step();
    a_in_32 = 32'hF0000000; b_in_32 = 32'h10000000;
    #1;
    chk("stall.fill1_ready", 131'(in_ready_32), 131'd1);
    step();
    a_in_32 = 32'h00000100; b_in_32 = 32'h00000001; op_sub_32 = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall.in_ready", 131'(in_ready_32), 131'd0);
      chk("stall.out_valid", 131'(out_valid_32), 131'd1);
      chk("stall.hold", res32(), e32(0, 0, 0, 32'h33333333));
      step();
    end
    chk("stall.still_held", res32(), e32(0, 0, 0, 32'h33333333));
    out_ready_32 = 1'b1;
    #1;
    chk("stall.release_ready", 131'(in_ready_32), 131'd1);
    step();
    in_valid_32 = 1'b0;
    chk("stall.second_valid", 131'(out_valid_32), 131'd1);
    chk("stall.second", res32(), e32(0, 1, 1, 32'h00000000));
    step();
    chk("stall.third_valid", 131'(out_valid_32), 131'd1);
    chk("stall.third", res32(), e32(0, 0, 1, 32'h000000FF));
    step();
    chk("stall.drained", 131'(out_valid_32), 131'd0);

    // Asynchronous reset with beats in flight
    a_in_32 = 32'hFFFFFFFF; b_in_32 = 32'hFFFFFFFF; c_in_32 = 0; op_sub_32 = 0;
    in_valid_32 = 1'b1;
    step();
    step();
    in_valid_32 = 1'b0;
    chk("midreset.pre_valid", 131'(out_valid_32), 131'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset.out_valid", 131'(out_valid_32), 131'd0);
    chk("midreset.outputs", res32(), 131'd0);
    chk("midreset.in_ready", 131'(in_ready_32), 131'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("midreset.no_stale", 131'(out_valid_32), 131'd0);
    end

    // WIDTH=64 full ripple and 4-cycle latency
    a_in_64 = '1; b_in_64 = '0; c_in_64 = 1; op_sub_64 = 0; in_valid_64 = 1'b1;
    step();
    in_valid_64 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("w64.latency_low", 131'(out_valid_64), 131'd0);
      step();
    end
    chk("w64.latency4", 131'(out_valid_64), 131'd1);
    chk("w64.ripple", res64(), {1'b0, 1'b1, 1'b1, 128'h0});
    step();

    // WIDTH=16 carry-out and 1-cycle latency
    a_in_16 = 16'hFFFF; b_in_16 = 16'h0001; c_in_16 = 0; op_sub_16 = 0; in_valid_16 = 1'b1;
    step();
    in_valid_16 = 1'b0;
    chk("w16.latency1", 131'(out_valid_16), 131'd1);
    chk("w16.wrap", res16(), {1'b0, 1'b1, 1'b1, 128'h0});
    step();

    // Randomized streams on the 16- and 64-bit builds
    for (int t = 0; t < NRND + 3; t++) begin
      if (t < NRND) begin
        a_in_16 = 16'($urandom); b_in_16 = 16'($urandom);
        c_in_16 = 1'($urandom_range(0, 1)); op_sub_16 = 1'($urandom_range(0, 1));
        a_in_64 = {$urandom, $urandom}; b_in_64 = {$urandom, $urandom};
        c_in_64 = 1'($urandom_range(0, 1)); op_sub_64 = 1'($urandom_range(0, 1));
        in_valid_16 = 1'b1; in_valid_64 = 1'b1;
        e16[t] = ref_model(16, 128'(a_in_16), 128'(b_in_16), c_in_16, op_sub_16);
        e64[t] = ref_model(64, 128'(a_in_64), 128'(b_in_64), c_in_64, op_sub_64);
      end else begin
        in_valid_16 = 1'b0; in_valid_64 = 1'b0;
      end
      #1;
      chk("rnd.in_ready16", 131'(in_ready_16), 131'd1);
      chk("rnd.in_ready64", 131'(in_ready_64), 131'd1);
      step();
      if (t < NRND) begin
        chk("rnd16.valid", 131'(out_valid_16), 131'd1);
        chk("rnd16.result", res16(), e16[t]);
      end
      if (t >= 3) begin
        chk("rnd64.valid", 131'(out_valid_64), 131'd1);
        chk("rnd64.result", res64(), e64[t-3]);
        $display("rnd beat %0d w64 sum=%h c=%b", t - 3, sum_out_64, c_out_64);
      end
    end
    step();
    chk("rnd.drained16", 131'(out_valid_16), 131'd0);
    chk("rnd.drained64", 131'(out_valid_64), 131'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
